// File: rtl/mul_unit.sv
// Iterative RV32M multiplier for the EX stage: unsigned chunk-accumulate on operand magnitudes, sign fix on output.
// Holds the pipeline with stall_mul from accept through the last iteration and presents the result in DONE.
module mul_unit #(
  parameter int CHUNK_BITS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  input  logic        hold,
  output logic        stall_mul,
  output logic        result_valid,
  output logic [31:0] result,
  output logic [4:0]  result_rd,
  output logic        busy
);

  localparam int N = 32 / CHUNK_BITS;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_next;
  logic [1:0]  op_q;
  logic [4:0]  rd_q;
  logic        neg_q;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [63:0] acc;
  logic [5:0]  count;

  logic        accept;
  logic        last_iter;
  logic        sa, sb;
  logic [31:0] mag_a, mag_b;
  logic [63:0] partial;
  logic [63:0] product;

  assign accept    = (state == IDLE) && in_valid && !flush;
  assign last_iter = (count == 6'(N - 1));

  // Only the signed forms of each operand contribute a sign; MUL uses the unsigned path.
  assign sa    = ((in_op == 2'b01) || (in_op == 2'b10)) && in_a[31];
  assign sb    = (in_op == 2'b01) && in_b[31];
  assign mag_a = sa ? (~in_a + 32'd1) : in_a;
  assign mag_b = sb ? (~in_b + 32'd1) : in_b;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state_next = CALC;
        CALC:    if (last_iter) state_next = DONE;
        DONE:    if (!hold) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // The multiplicand is pre-shifted each iteration so the current chunk's weight is always in place.
  assign partial = mcand * 64'(mplier[CHUNK_BITS-1:0]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q   <= 2'b00;
      rd_q   <= 5'd0;
      neg_q  <= 1'b0;
      mcand  <= 64'd0;
      mplier <= 32'd0;
      acc    <= 64'd0;
      count  <= 6'd0;
    end else if (accept) begin
      op_q   <= in_op;
      rd_q   <= in_rd;
      neg_q  <= sa ^ sb;
      mcand  <= {32'd0, mag_a};
      mplier <= mag_b;
      acc    <= 64'd0;
      count  <= 6'd0;
    end else if ((state == CALC) && !flush) begin
      acc    <= acc + partial;
      mcand  <= mcand << CHUNK_BITS;
      mplier <= 32'(64'(mplier) >> CHUNK_BITS);
      count  <= count + 6'd1;
    end
  end

  assign product      = neg_q ? (~acc + 64'd1) : acc;
  assign result_valid = (state == DONE) && !flush;
  assign result       = !result_valid ? 32'd0 : ((op_q == 2'b00) ? product[31:0] : product[63:32]);
  assign result_rd    = result_valid ? rd_q : 5'd0;
  assign busy         = (state != IDLE);
  // Gated by reset so the pipeline is released the instant reset asserts.
  assign stall_mul    = !reset && (accept || (state == CALC));

endmodule

// File: doc/mul_unit.md
# mul_unit

Multi-cycle integer multiplier that sits in the EX stage beside the ALU. It consumes multiply instructions held in the ID/EX pipeline register and produces the `stall_mul` control signal that freezes the pipeline registers while it works. It returns a 32-bit result in the cycle the pipeline is released, so EX/MEM captures it like an ALU result. It implements RV32M MUL/MULH/MULHSU/MULHU with an iterative unsigned chunk-accumulate datapath and a final sign fix.

## Interface
- CHUNK_BITS, 8, multiplier bits consumed per iteration; legal values 1, 2, 4, 8, 16, 32; N = 32/CHUNK_BITS iterations
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  ID/EX holds a valid multiply instruction
- in_op  in  2  00 MUL (low 32), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high)
- in_a, in_b  in  32  rs1, rs2 operand values (already forwarded)
- in_rd  in  5  destination register
- flush  in  1  exception or flush: kill in-flight operation
- hold  in  1  downstream (dcache) stall: keep result presented
- stall_mul  out  1  freeze IF/ID, ID/EX, EX/MEM
- result_valid  out  1  result and result_rd are valid this cycle
- result  out  32  selected product half
- result_rd  out  5  destination of the result
- busy  out  1  state != IDLE

## Operation
- States: IDLE, CALC, DONE. Reset: state IDLE, count 0, all datapath registers 0. Outputs at reset: stall_mul 0, result_valid 0, result 0, result_rd 0, busy 0.
- IDLE: when in_valid && !flush, capture op, rd, |a| and |b| magnitudes, and neg = sa ^ sb. Clear the 64-bit accumulator and count, then go to CALC.
  - sa = a[31] for MULH/MULHSU, else 0.
  - sb = b[31] for MULH, else 0.
  - MUL is treated as unsigned; only the low half is used.
- CALC: acc += (|a| × |b| chunk[count]) << (count×CHUNK_BITS), with chunks taken LSB first and arithmetic 64-bit unsigned. count increments each cycle. After iteration N-1, go to DONE.
- DONE: p = neg ? (~acc + 1) : acc (64-bit).
  - result = p[31:0] for MUL, p[63:32] otherwise.
  - result_rd = captured rd.
  - result_valid = 1.
  - Stay in DONE while hold=1; otherwise go to IDLE.
- stall_mul (combinational) = (in_valid && state==IDLE && !flush) || state==CALC. It is 0 in DONE, so the pipeline advances and captures the result.
- result and result_rd are 0 whenever result_valid=0.
- flush has priority in any state: the next state is IDLE and result_valid is forced 0 in that cycle. A flush in DONE drops the result.
- Operands are captured at accept. Changes on in_a/in_b during CALC are ignored.

## Timing
- Accept cycle (cycle 0, IDLE): stall_mul=1.
- Cycles 1..N (CALC): stall_mul=1.
- Cycle N+1 (DONE): result_valid=1, stall_mul=0.
- Total: N+1 stall cycles, and the instruction spends N+2 cycles in EX. With CHUNK_BITS=8 there are 5 stall cycles and the result appears in cycle 5.
- Back-to-back: a multiply entering ID/EX at the edge ending DONE is accepted the very next cycle. There is no idle gap.
- hold in DONE: result_valid, result and result_rd stay stable for every held cycle. The DONE→IDLE transition happens on the first edge with hold=0.
- reset mid-operation: outputs go to reset values immediately (asynchronous). The first operation after reset is accepted normally.
- in_valid dropping during CALC (which only happens via flush) has no effect without flush.

## Test plan
- MUL 7×6, CHUNK_BITS=8 -> stall_mul=1 for exactly cycles 0–4; cycle 5 has result_valid=1, result=42, result_rd=in_rd, stall_mul=0.
- MULH 0x80000000×0x80000000 -> 0x40000000. MUL 0xFFFFFFFF×0xFFFFFFFF -> 0x00000001. MULH 0xFFFFFFFF×0xFFFFFFFF -> 0x00000000.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF. MULHSU 0x00000002×0x80000000 -> 0x00000001.
- Flush asserted in CALC cycle 2 -> next cycle IDLE, no result_valid pulse. A following MUL 3×5 returns 15 with normal latency. Flush in DONE -> result_valid=0 that cycle.
- Back-to-back MUL 2×3 then MUL 4×5 -> result_valid pulses at cycles 5 and 11 with values 6 and 20, and stall_mul=0 only in cycles 5 and 11.
- hold=1 for 3 cycles in DONE -> result stays stable for 4 cycles. Async reset pulse in CALC -> all outputs 0 immediately, and a subsequent operation is correct. Sweep CHUNK_BITS ∈ {1,4,32} against a reference model with random operands and ops.
